// File: rtl/uart_tx_sched_pkg.sv
// Shared FSM encoding, parameter defaults and width helper for the UART transmit scheduler.
package uart_tx_sched_pkg;

  localparam int NREQ_DEF        = 2;
  localparam int DEPTH_DEF       = 16;
  localparam int ACK_TIMEOUT_DEF = 4;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_START     = 2'd1,
    S_WAIT_ACK  = 2'd2,
    S_WAIT_DONE = 2'd3
  } state_e;

  // Ceiling log2; returns 0 for values <= 1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Circular DEPTH x 8 byte FIFO; head byte readable combinationally, level registered, one-edge push-to-visible.
// Push ignored when full and pop ignored when empty, so callers gate on full_o/empty_o.
module uart_tx_fifo
  import uart_tx_sched_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic        push_vld_i,
  input  logic [7:0]  push_dat_i,
  input  logic        pop_i,
  output logic [7:0]  pop_dat_o,
  output logic        full_o,
  output logic        empty_o,
  output logic [AW:0] level_o
);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   level_q;
  logic [AW:0]   level_d;
  logic          do_push;
  logic          do_pop;

  assign full_o    = (level_q == (AW+1)'(DEPTH));
  assign empty_o   = (level_q == '0);
  assign do_push   = push_vld_i & ~full_o;
  assign do_pop    = pop_i & ~empty_o;
  assign pop_dat_o = mem_q[rd_ptr_q];
  assign level_o   = level_q;

  always_comb begin
    level_d = level_q;
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + (AW+1)'(1);
      2'b01:   level_d = level_q - (AW+1)'(1);
      default: level_d = level_q;
    endcase
  end

  // Storage needs no reset: only entries below the level are ever read.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_dat_i;
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      level_q <= level_d;
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Shares one UART transmitter among NREQ byte requesters: round-robin packet-locked arbiter -> FIFO -> start/busy FSM.
// Accepted byte raises tx_start 2 edges later; req_ready only for the selected requester and drops while the FIFO is full.
module uart_tx_sched
  import uart_tx_sched_pkg::*;
#(
  parameter int NREQ        = NREQ_DEF,
  parameter int DEPTH       = DEPTH_DEF,
  parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
  input  logic                    clk,
  input  logic                    clrn,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [8*NREQ-1:0]       req_data,
  input  logic [NREQ-1:0]         req_last,
  output logic [NREQ-1:0]         req_ready,
  output logic                    tx_start,
  output logic [7:0]              tx_data,
  input  logic                    tx_busy,
  output logic [clog2(DEPTH):0]   fifo_level,
  output logic                    ack_err,
  output logic                    idle
);

  localparam int OW = clog2(NREQ);
  localparam int CW = clog2(ACK_TIMEOUT);

  logic [OW-1:0] owner_q, owner_d;
  logic          locked_q, locked_d;
  logic [OW-1:0] sel;
  logic [OW-1:0] cand;
  logic          grant;
  logic          accept;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          ack_err_q, ack_err_d;
  logic          pop;
  logic [7:0]    fifo_dat;
  logic          fifo_full;
  logic          fifo_empty;

  // Descending scan so the last hit is the nearest requester after the owner.
  always_comb begin
    sel   = owner_q;
    cand  = owner_q;
    grant = locked_q;
    if (!locked_q) begin
      for (int k = NREQ; k >= 1; k--) begin
        cand = OW'((int'(owner_q) + k) % NREQ);
        if (req_valid[cand]) begin
          sel   = cand;
          grant = 1'b1;
        end
      end
    end
  end

  always_comb begin
    req_ready      = '0;
    req_ready[sel] = grant & ~fifo_full;
  end

  assign accept = grant & ~fifo_full & req_valid[sel];

  always_comb begin
    owner_d  = owner_q;
    locked_d = locked_q;
    if (accept) begin
      owner_d  = sel;
      locked_d = ~req_last[sel];
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      owner_q  <= OW'(NREQ - 1);
      locked_q <= 1'b0;
    end else begin
      owner_q  <= owner_d;
      locked_q <= locked_d;
    end
  end

  uart_tx_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .clrn       (clrn),
    .push_vld_i (accept),
    .push_dat_i (req_data[{sel, 3'b000} +: 8]),
    .pop_i      (pop),
    .pop_dat_o  (fifo_dat),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .level_o    (fifo_level)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tx_data_d = tx_data_q;
    ack_err_d = ack_err_q;
    pop       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty && !tx_busy) begin
          pop       = 1'b1;
          tx_data_d = fifo_dat;
          state_d   = S_START;
        end
      end
      S_START: begin
        cnt_d   = '0;
        state_d = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        // Byte is dropped on timeout; the transmitter never took it.
        if (tx_busy) begin
          state_d = S_WAIT_DONE;
        end else if (cnt_q == CW'(ACK_TIMEOUT - 1)) begin
          ack_err_d = 1'b1;
          state_d   = S_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_WAIT_DONE: begin
        if (!tx_busy) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      tx_data_q <= 8'h00;
      ack_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tx_data_q <= tx_data_d;
      ack_err_q <= ack_err_d;
    end
  end

  assign tx_start = (state_q == S_START);
  assign tx_data  = tx_data_q;
  assign ack_err  = ack_err_q;
  assign idle     = (state_q == S_IDLE) & fifo_empty & ~locked_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched (NREQ=2, DEPTH=16, ACK_TIMEOUT=4) with a simple transmitter busy model.
module tb_uart_tx_sched;

  logic        clk = 1'b0;
  logic        clrn;
  logic [1:0]  req_valid;
  logic [15:0] req_data;
  logic [1:0]  req_last;
  logic [1:0]  req_ready;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_busy;
  logic [4:0]  fifo_level;
  logic        ack_err;
  logic        idle;

  int vecs = 0;
  int errs = 0;

  // Transmitter model: busy rises the edge after a start is seen, stays up 10 cycles.
  logic       model_en  = 1'b1;
  logic       hold_busy = 1'b0;
  logic       start_seen = 1'b0;
  int         busy_cnt = 0;
  int         n_starts = 0;
  logic [7:0] tx_log[$];

  logic [7:0] exp3[4] = '{8'hA0, 8'hB0, 8'hA1, 8'hB1};
  logic [7:0] exp4[4] = '{8'h01, 8'h02, 8'h03, 8'hC0};

  always #5 clk = ~clk;

  always @(negedge clk) begin
    start_seen = tx_start & model_en;
    if (tx_start) begin
      n_starts++;
      tx_log.push_back(tx_data);
    end
  end

  always @(posedge clk) begin
    if (start_seen) busy_cnt <= 10;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end

  assign tx_busy = hold_busy | (busy_cnt != 0);

  uart_tx_sched dut (
    .clk        (clk),
    .clrn       (clrn),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_last   (req_last),
    .req_ready  (req_ready),
    .tx_start   (tx_start),
    .tx_data    (tx_data),
    .tx_busy    (tx_busy),
    .fifo_level (fifo_level),
    .ack_err    (ack_err),
    .idle       (idle)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    clrn      = 1'b0;
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    repeat (2) @(negedge clk);
    clrn = 1'b1;
  endtask

  task automatic wait_idle(input string tag);
    int c = 0;
    @(negedge clk);
    while (!idle && c < 300) begin
      @(negedge clk);
      c++;
    end
    chk(tag, idle, 1);
  endtask

  task automatic wait_log(input string tag, input int n);
    int c = 0;
    while (tx_log.size() < n && c < 1000) begin
      @(posedge clk);
      c++;
    end
    chk(tag, tx_log.size(), n);
  endtask

  initial begin
    // 1: reset values and quiet idle
    clrn      = 1'b0;
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    @(negedge clk);
    chk("rst_level", fifo_level, 0);
    chk("rst_start", tx_start, 0);
    chk("rst_data", tx_data, 0);
    chk("rst_ackerr", ack_err, 0);
    chk("rst_ready", req_ready, 0);
    @(negedge clk);
    clrn = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("t1_idle", idle, 1);
    chk("t1_nostarts", n_starts, 0);
    chk("t1_level", fifo_level, 0);
    chk("t1_ready", req_ready, 0);

    // 2: single byte from req0, exact latency
    @(posedge clk); #1;
    req_valid = 2'b01; req_data[7:0] = 8'h55; req_last = 2'b01;
    @(negedge clk);
    chk("t2_ready", req_ready, 2'b01);
    @(posedge clk); #1;
    req_valid = 2'b00;
    @(negedge clk);
    chk("t2_level1", fifo_level, 1);
    chk("t2_nostart", tx_start, 0);
    @(negedge clk);
    chk("t2_start", tx_start, 1);
    chk("t2_data", tx_data, 8'h55);
    chk("t2_level0", fifo_level, 0);
    @(negedge clk);
    chk("t2_start_pulse", tx_start, 0);
    repeat (13) @(negedge clk);
    chk("t2_idle", idle, 1);
    chk("t2_one_start", n_starts, 1);
    chk("t2_data_hold", tx_data, 8'h55);
    chk("t2_ackerr", ack_err, 0);

    // 3: round-robin alternation after reset
    do_reset();
    tx_log.delete();
    @(posedge clk); #1;
    req_valid = 2'b11; req_last = 2'b11; req_data = {8'hB0, 8'hA0};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t3_grant", req_ready, (i % 2 == 0) ? 2'b01 : 2'b10);
      @(posedge clk); #1;
      if (i == 0) req_data[7:0]  = 8'hA1;
      if (i == 1) req_data[15:8] = 8'hB1;
      if (i == 2) req_valid[0]   = 1'b0;
      if (i == 3) req_valid      = 2'b00;
    end
    wait_log("t3_count", 4);
    for (int i = 0; i < 4; i++) chk("t3_order", tx_log[i], exp3[i]);

    // 4: packet lock held by req1, including an owner valid gap
    tx_log.delete();
    @(posedge clk); #1;
    req_valid = 2'b10; req_data[15:8] = 8'h01; req_last = 2'b00;
    @(negedge clk);
    chk("t4_first", req_ready, 2'b10);
    @(posedge clk); #1;
    req_valid = 2'b11; req_data = {8'h02, 8'hC0}; req_last = 2'b01;
    @(negedge clk);
    chk("t4_locked_b2", req_ready, 2'b10);
    @(posedge clk); #1;
    req_valid = 2'b01;
    @(negedge clk);
    chk("t4_owner_gap", req_ready, 2'b10);
    @(posedge clk); #1;
    req_valid = 2'b11; req_data[15:8] = 8'h03; req_last = 2'b11;
    @(negedge clk);
    chk("t4_locked_b3", req_ready, 2'b10);
    @(posedge clk); #1;
    req_valid = 2'b01;
    @(negedge clk);
    chk("t4_release", req_ready, 2'b01);
    @(posedge clk); #1;
    req_valid = 2'b00;
    wait_log("t4_count", 4);
    for (int i = 0; i < 4; i++) chk("t4_order", tx_log[i], exp4[i]);

    // 5: fill to DEPTH under held busy, then drain in order
    wait_idle("t5_idle_before");
    tx_log.delete();
    hold_busy = 1'b1;
    @(posedge clk); #1;
    req_valid = 2'b01; req_last = 2'b01; req_data[7:0] = 8'h10;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk("t5_fill_ready", req_ready, 2'b01);
      @(posedge clk); #1;
      req_data[7:0] = 8'(8'h11 + i);
    end
    @(negedge clk);
    chk("t5_full_level", fifo_level, 16);
    chk("t5_full_ready", req_ready, 2'b00);
    @(posedge clk); #1;
    hold_busy = 1'b0;
    @(negedge clk);
    chk("t5_still_full", req_ready, 2'b00);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t5_level_after_pop", fifo_level, 15);
    chk("t5_ready_back", req_ready, 2'b01);
    @(posedge clk); #1;
    req_valid = 2'b00;
    @(negedge clk);
    chk("t5_refill", fifo_level, 16);
    wait_log("t5_count", 17);
    for (int i = 0; i < 17; i++) chk("t5_order", tx_log[i], 8'(8'h10 + i));
    chk("t5_ackerr", ack_err, 0);

    // 6: transmitter never acknowledges, then reset mid-transfer
    wait_idle("t6_idle_before");
    model_en = 1'b0;
    @(posedge clk); #1;
    req_valid = 2'b01; req_last = 2'b01; req_data[7:0] = 8'h66;
    @(posedge clk); #1;
    req_data[7:0] = 8'h77;
    @(posedge clk); #1;
    req_valid = 2'b00;
    @(negedge clk);
    chk("t6_start", tx_start, 1);
    chk("t6_data", tx_data, 8'h66);
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("t6_no_err_yet", ack_err, 0);
    @(posedge clk);
    @(negedge clk);
    chk("t6_ackerr", ack_err, 1);
    chk("t6_back_idle_start", tx_start, 0);
    chk("t6_level", fifo_level, 1);
    @(posedge clk);
    @(negedge clk);
    chk("t6_next_start", tx_start, 1);
    chk("t6_next_data", tx_data, 8'h77);
    chk("t6_err_sticky", ack_err, 1);
    clrn = 1'b0;
    #1;
    chk("t6_rst_start", tx_start, 0);
    chk("t6_rst_data", tx_data, 0);
    chk("t6_rst_ackerr", ack_err, 0);
    chk("t6_rst_level", fifo_level, 0);
    chk("t6_rst_ready", req_ready, 0);
    chk("t6_rst_idle", idle, 1);
    @(negedge clk);
    clrn = 1'b1;
    @(negedge clk);
    chk("t6_post_idle", idle, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
